// File: rtl/multiphase_clk_gen.sv
// N-phase non-overlapping clock generator: frames of NUM_PHASES slots plus an idle tail.
// Optional single-frame step control is compiled in with `define MPCLK_STEP_EN.
module multiphase_clk_gen #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 6,
    parameter int HIGH_DEF   = 4,
    parameter int SLOT_DEF   = 8,
    parameter int TAIL_TICKS = 32,
    parameter int FCNT_W     = 16
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  cfg_load,
    input  logic [CNT_W-1:0]      cfg_high,
    input  logic [CNT_W-1:0]      cfg_slot,
    output logic [NUM_PHASES-1:0] phase_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic [FCNT_W-1:0]     frame_count,
    output logic                  cfg_err
);
    localparam int SEG_W = $clog2(NUM_PHASES + 1);
    localparam logic [SEG_W-1:0] TAIL_SEG = SEG_W'(NUM_PHASES);
    // With no tail the frame ends on the last phase slot.
    localparam logic [SEG_W-1:0] LAST_SEG  = (TAIL_TICKS > 0) ? SEG_W'(NUM_PHASES) : SEG_W'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = (TAIL_TICKS > 0) ? CNT_W'(TAIL_TICKS - 1) : '0;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t                  state, state_n;
    logic [SEG_W-1:0]        seg, seg_n;
    logic [CNT_W-1:0]        tick, tick_n;
    logic [CNT_W-1:0]        high_r, high_n, slot_r, slot_n;
    logic [CNT_W-1:0]        seg_last, seg_last_n;
    logic                    cfg_ok, start, seg_end, frame_end, busy_n, last_n;
    logic [NUM_PHASES-1:0]   phase_n;

`ifdef MPCLK_STEP_EN
    assign start = run | step;
`else
    logic step_unused;
    assign step_unused = step;
    assign start = run;
`endif

    always_comb begin
        cfg_ok   = (cfg_high != '0) && (cfg_high < cfg_slot);
        high_n   = high_r;
        slot_n   = slot_r;
        if (state == IDLE && cfg_load && cfg_ok) begin
            high_n = cfg_high;
            slot_n = cfg_slot;
        end

        seg_last  = (seg == TAIL_SEG) ? TAIL_LAST : slot_r - CNT_W'(1);
        seg_end   = (tick == seg_last);
        frame_end = seg_end && (seg == LAST_SEG);

        state_n = state;
        seg_n   = seg;
        tick_n  = tick;
        case (state)
            IDLE: begin
                // run wins over step; a lone step runs exactly one frame
                if (start) begin
                    state_n = run ? RUN : STOPPING;
                    seg_n   = '0;
                    tick_n  = '0;
                end
            end
            default: begin
                state_n = run ? RUN : STOPPING;
                if (frame_end) begin
                    seg_n  = '0;
                    tick_n = '0;
                    if (!run) state_n = IDLE;
                end else if (seg_end) begin
                    seg_n  = seg + SEG_W'(1);
                    tick_n = '0;
                end else begin
                    tick_n = tick + CNT_W'(1);
                end
            end
        endcase

        // Outputs are decoded from the next position so they are registered.
        busy_n     = (state_n != IDLE);
        seg_last_n = (seg_n == TAIL_SEG) ? TAIL_LAST : slot_n - CNT_W'(1);
        last_n     = busy_n && (seg_n == LAST_SEG) && (tick_n == seg_last_n);
        for (int i = 0; i < NUM_PHASES; i++)
            phase_n[i] = busy_n && (seg_n == SEG_W'(i)) && (tick_n < high_n);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= IDLE;
            seg         <= '0;
            tick        <= '0;
            high_r      <= CNT_W'(HIGH_DEF);
            slot_r      <= CNT_W'(SLOT_DEF);
            phase_out   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            state      <= state_n;
            seg        <= seg_n;
            tick       <= tick_n;
            high_r     <= high_n;
            slot_r     <= slot_n;
            phase_out  <= phase_n;
            busy       <= busy_n;
            frame_done <= last_n;
            cfg_err    <= cfg_load && !(state == IDLE && cfg_ok);
            if (state != IDLE && frame_end && frame_count != '1)
                frame_count <= frame_count + FCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Scoreboard bench for multiphase_clk_gen: frame-offset arithmetic model feeds a queue,
// a negedge monitor compares every registered output cycle by cycle.
module tb_multiphase_clk_gen;
    localparam int NP = 4, CW = 6, HD = 4, SD = 8, TT = 32, FW = 16;
`ifdef MPCLK_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          reset = 1'b1, run = 1'b0, step = 1'b0, cfg_load = 1'b0;
    logic [CW-1:0] cfg_high = '0, cfg_slot = '0;
    logic [NP-1:0] phase_out;
    logic          busy, frame_done, cfg_err;
    logic [FW-1:0] frame_count;

    multiphase_clk_gen #(.NUM_PHASES(NP), .CNT_W(CW), .HIGH_DEF(HD), .SLOT_DEF(SD),
                         .TAIL_TICKS(TT), .FCNT_W(FW)) dut (
        .clk_in(clk_in), .reset(reset), .run(run), .step(step), .cfg_load(cfg_load),
        .cfg_high(cfg_high), .cfg_slot(cfg_slot), .phase_out(phase_out), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count), .cfg_err(cfg_err));

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [NP-1:0] ph;
        logic          busy;
        logic          fd;
        logic [FW-1:0] fc;
        logic          err;
    } obs_t;

    obs_t q[$];
    int   checks = 0, passed = 0;

    // Model: a frame is just an offset k into NP*sl + TT cycles.
    bit m_busy = 1'b0;
    int k = 0, hi = HD, sl = SD, fc = 0;

    task automatic model_step();
        obs_t e;
        int   flen;
        bit   legal;
        e = '0;
        if (reset) begin
            m_busy = 1'b0; k = 0; hi = HD; sl = SD; fc = 0;
        end else begin
            legal = (cfg_high >= 1) && (cfg_high < cfg_slot);
            e.err = cfg_load && (m_busy || !legal);
            if (!m_busy) begin
                if (cfg_load && legal) begin hi = cfg_high; sl = cfg_slot; end
                if (run || (STEP_EN && step)) begin m_busy = 1'b1; k = 0; end
            end else begin
                flen = NP * sl + TT;
                if (k == flen - 1) begin
                    if (fc < (1 << FW) - 1) fc++;
                    if (run) k = 0; else m_busy = 1'b0;
                end else begin
                    k++;
                end
            end
            flen = NP * sl + TT;
            if (m_busy && k < NP * sl && (k % sl) < hi) e.ph = NP'(1) << (k / sl);
            e.busy = m_busy;
            e.fd   = m_busy && (k == flen - 1);
            e.fc   = FW'(fc);
        end
        q.push_back(e);
    endtask

    task automatic drive(input bit rs, input bit r, input bit st, input bit ld,
                         input logic [CW-1:0] ch, input logic [CW-1:0] cs);
        reset = rs; run = r; step = st; cfg_load = ld; cfg_high = ch; cfg_slot = cs;
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic hold(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, r, 1'b0, 1'b0, '0, '0);
    endtask

    always @(negedge clk_in) begin : monitor
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {phase_out, busy, frame_done, frame_count, cfg_err};
            checks++;
            if (a === e) passed++;
            else $display("FAIL outputs @%0t: got ph=%b busy=%b fd=%b fc=%0d err=%b, want ph=%b busy=%b fd=%b fc=%0d err=%b",
                          $time, a.ph, a.busy, a.fd, a.fc, a.err, e.ph, e.busy, e.fd, e.fc, e.err);
        end
    end

    initial begin
        bit run_lvl;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        hold(3, 1'b0);
        // default frame, run dropped at R+10
        hold(11, 1'b1);
        hold(70, 1'b0);
        // back-to-back frames then stop
        hold(140, 1'b1);
        hold(80, 1'b0);
        // narrow config 2/5
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 6'd5);
        hold(52, 1'b1);
        hold(60, 1'b0);
        // load and run in the same cycle restores defaults
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd4, 6'd8);
        hold(20, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd2, 6'd6);
        hold(60, 1'b0);
        // illegal config values
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 6'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd5);
        hold(2, 1'b0);
        // reset mid-frame with run held
        hold(11, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        hold(30, 1'b1);
        hold(80, 1'b0);
        // single step pulse
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        hold(80, 1'b0);
        // step together with run, then random traffic
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        run_lvl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) run_lvl = ~run_lvl;
            drive($urandom_range(0, 699) == 0, run_lvl, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 14) == 0, CW'($urandom_range(0, 7)), CW'($urandom_range(0, 9)));
        end
        hold(4, 1'b0);
        @(negedge clk_in);
        #1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending entries, want 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
